rbus_axi_arb2: RTL and testbench

- 2:1 AXI4 arbiter that merges the master ports of two memory hubs (HUB_ID 0 and 1) onto a single memory-controller AXI slave port.
- Sits directly downstream of the hubs.
- Arbitrates AW and AR round-robin, orders W data by AW grant order, and routes B/R responses back by ID bit 1.
- Fixed burst: 8 beats × 64 bit, INCR, size 3.

---
 rtl/rbus_axi_arb_pkg.sv | 16 +
 rtl/rbus_axi_arb_ordfifo.sv | 51 +++++
 rtl/rbus_axi_arb2.sv | 232 +++++++++++++++++++++++
 tb/tb_rbus_axi_arb2.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbus_axi_arb_pkg.sv
// rtl/rbus_axi_arb_pkg.sv - shared constants, FSM state type and round-robin helper for rbus_axi_arb2
package rbus_axi_arb_pkg;

  localparam int         BURST_LEN      = 8;
  localparam logic [7:0] AXI_LEN        = 8'(BURST_LEN - 1);
  localparam logic [2:0] AXI_SIZE       = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {A_IDLE, A_ISSUE} arb_st_t;

  // prio names the port that wins a tie; a lone requester always wins
  function automatic logic rr_pick(input logic req0, input logic req1, input logic prio);
    return (req0 & req1) ? prio : req1;
  endfunction

endpackage

// File: rtl/rbus_axi_arb_ordfifo.sv
// rtl/rbus_axi_arb_ordfifo.sv - 1-bit write-order FIFO holding the port index of each granted AW
module rbus_axi_arb_ordfifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rbus_axi_arb2.sv
// rtl/rbus_axi_arb2.sv - 2:1 AXI4 hub arbiter; RBUS_AXI_ARB_ERR_EN adds a sticky err output
module rbus_axi_arb2
  import rbus_axi_arb_pkg::*;
#(
  parameter int WR_ORD_DEPTH = 4,
  parameter int ADDR_W       = 29
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RBUS_AXI_ARB_ERR_EN
  output logic              err,
`endif
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [1:0]        s0_awid,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [63:0]       s0_wdata,
  input  logic [7:0]        s0_wstrb,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bid,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [1:0]        s0_arid,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [63:0]       s0_rdata,
  output logic [1:0]        s0_rid,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [1:0]        s1_awid,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [63:0]       s1_wdata,
  input  logic [7:0]        s1_wstrb,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bid,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [1:0]        s1_arid,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [63:0]       s1_rdata,
  output logic [1:0]        s1_rid,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [1:0]        m_awid,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [1:0]        m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  arb_st_t aw_st, ar_st;
  logic    aw_prio, ar_prio;
  logic    aw_sel, ar_sel;
  logic    aw_grant, ar_grant;
  logic    ord_push, ord_pop, ord_head, ord_full, ord_empty;
  logic    unused_id_bits;

  assign m_awlen   = AXI_LEN;
  assign m_awsize  = AXI_SIZE;
  assign m_awburst = AXI_BURST_INCR;
  assign m_arlen   = AXI_LEN;
  assign m_arsize  = AXI_SIZE;
  assign m_arburst = AXI_BURST_INCR;

  // ID bit 1 is overwritten with the port index, so the hubs' own bit 1 is dropped
  assign unused_id_bits = ^{s0_awid[1], s1_awid[1], s0_arid[1], s1_arid[1]};

  assign aw_sel     = rr_pick(s0_awvalid, s1_awvalid, aw_prio);
  assign aw_grant   = rst & (aw_st == A_IDLE) & ~ord_full & (s0_awvalid | s1_awvalid);
  assign s0_awready = aw_grant & ~aw_sel;
  assign s1_awready = aw_grant & aw_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_st     <= A_IDLE;
      aw_prio   <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awid    <= '0;
    end else begin
      case (aw_st)
        A_IDLE: if (aw_grant) begin
          m_awaddr  <= aw_sel ? s1_awaddr : s0_awaddr;
          m_awid    <= {aw_sel, aw_sel ? s1_awid[0] : s0_awid[0]};
          aw_prio   <= ~aw_sel;
          m_awvalid <= 1'b1;
          aw_st     <= A_ISSUE;
        end
        A_ISSUE: if (m_awready) begin
          m_awvalid <= 1'b0;
          aw_st     <= A_IDLE;
        end
        default: aw_st <= A_IDLE;
      endcase
    end
  end

  // the order entry is recorded only once the controller has taken the AW
  assign ord_push = (aw_st == A_ISSUE) & m_awready;
  assign ord_pop  = m_wvalid & m_wready & m_wlast;

  rbus_axi_arb_ordfifo #(.DEPTH(WR_ORD_DEPTH)) u_ordfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ord_push),
    .din   (m_awid[1]),
    .pop   (ord_pop),
    .dout  (ord_head),
    .full  (ord_full),
    .empty (ord_empty)
  );

  assign m_wdata   = ord_head ? s1_wdata : s0_wdata;
  assign m_wstrb   = ord_head ? s1_wstrb : s0_wstrb;
  assign m_wlast   = ord_head ? s1_wlast : s0_wlast;
  assign m_wvalid  = ~ord_empty & (ord_head ? s1_wvalid : s0_wvalid);
  assign s0_wready = ~ord_empty & ~ord_head & m_wready;
  assign s1_wready = ~ord_empty & ord_head & m_wready;

  assign ar_sel     = rr_pick(s0_arvalid, s1_arvalid, ar_prio);
  assign ar_grant   = rst & (ar_st == A_IDLE) & (s0_arvalid | s1_arvalid);
  assign s0_arready = ar_grant & ~ar_sel;
  assign s1_arready = ar_grant & ar_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_st     <= A_IDLE;
      ar_prio   <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arid    <= '0;
    end else begin
      case (ar_st)
        A_IDLE: if (ar_grant) begin
          m_araddr  <= ar_sel ? s1_araddr : s0_araddr;
          m_arid    <= {ar_sel, ar_sel ? s1_arid[0] : s0_arid[0]};
          ar_prio   <= ~ar_sel;
          m_arvalid <= 1'b1;
          ar_st     <= A_ISSUE;
        end
        A_ISSUE: if (m_arready) begin
          m_arvalid <= 1'b0;
          ar_st     <= A_IDLE;
        end
        default: ar_st <= A_IDLE;
      endcase
    end
  end

  assign s0_bid    = m_bid;
  assign s1_bid    = m_bid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign s0_bvalid = rst & m_bvalid & ~m_bid[1];
  assign s1_bvalid = rst & m_bvalid & m_bid[1];
  assign m_bready  = rst & (m_bid[1] ? s1_bready : s0_bready);

  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rid    = m_rid;
  assign s1_rid    = m_rid;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign s0_rvalid = rst & m_rvalid & ~m_rid[1];
  assign s1_rvalid = rst & m_rvalid & m_rid[1];
  assign m_rready  = rst & (m_rid[1] ? s1_rready : s0_rready);

`ifdef RBUS_AXI_ARB_ERR_EN
  logic [3:0] stray_cnt0, stray_cnt1;
  logic       stray0, stray1;

  // a port offering W data it does not own, held for 16 cycles in a row, is a protocol fault
  assign stray0 = s0_wvalid & (ord_empty | ord_head);
  assign stray1 = s1_wvalid & (ord_empty | ~ord_head);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= 1'b0;
      stray_cnt0 <= '0;
      stray_cnt1 <= '0;
    end else begin
      stray_cnt0 <= !stray0 ? 4'd0 : (stray_cnt0 == 4'hF) ? stray_cnt0 : stray_cnt0 + 4'd1;
      stray_cnt1 <= !stray1 ? 4'd0 : (stray_cnt1 == 4'hF) ? stray_cnt1 : stray_cnt1 + 4'd1;
      if ((m_bvalid & m_bready & |m_bresp) | (m_rvalid & m_rready & |m_rresp) |
          (stray0 & (stray_cnt0 == 4'hF)) | (stray1 & (stray_cnt1 == 4'hF)))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rbus_axi_arb2.sv
// tb/tb_rbus_axi_arb2.sv - directed self-checking bench for rbus_axi_arb2
module tb_rbus_axi_arb2;

  localparam int ADDR_W = 29;

  logic clk, rst;
`ifdef RBUS_AXI_ARB_ERR_EN
  logic err;
`endif
  logic [ADDR_W-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
  logic [1:0]  s0_awid, s1_awid, s0_arid, s1_arid, m_awid, m_arid;
  logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [63:0] s0_wdata, s1_wdata, m_wdata;
  logic [7:0]  s0_wstrb, s1_wstrb, m_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [1:0]  s0_bid, s1_bid, s0_bresp, s1_bresp;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [63:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rid, s1_rid, s0_rresp, s1_rresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bid, m_bresp, m_rid, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic [63:0] m_rdata;
  logic        m_rlast, m_rvalid, m_rready;

  int total = 0;
  int bad   = 0;

  rbus_axi_arb2 dut (
    .clk(clk), .rst(rst),
`ifdef RBUS_AXI_ARB_ERR_EN
    .err(err),
`endif
    .s0_awaddr(s0_awaddr), .s0_awid(s0_awid), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awid(s1_awid), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arid(s1_arid), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rid(s1_rid), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wd(input int p, input int r, input int b);
    return {16'hCAFE, 8'(p), 8'(r), 32'(b)};
  endfunction

  task automatic clear_inputs();
    s0_awaddr = '0; s0_awid = '0; s0_awvalid = 0; s1_awaddr = '0; s1_awid = '0; s1_awvalid = 0;
    s0_wdata = '0; s0_wstrb = 8'hFF; s0_wlast = 0; s0_wvalid = 0;
    s1_wdata = '0; s1_wstrb = 8'hFF; s1_wlast = 0; s1_wvalid = 0;
    s0_bready = 0; s1_bready = 0; s0_rready = 0; s1_rready = 0;
    s0_araddr = '0; s0_arid = '0; s0_arvalid = 0; s1_araddr = '0; s1_arid = '0; s1_arvalid = 0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0; m_arready = 0;
    m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    s0_awvalid = 1; s1_arvalid = 1; s0_wvalid = 1; m_bvalid = 1; m_rvalid = 1; m_rid = 2'b10;
    s0_bready = 1; s1_rready = 1;
    @(negedge clk); #1;
    total++; if ({m_awvalid, m_arvalid, m_wvalid} !== 3'b000) begin
      bad++; $display("FAIL reset_mvalid got=%b exp=000", {m_awvalid, m_arvalid, m_wvalid}); end
    total++; if ({s0_awready, s1_awready, s0_arready, s1_arready, s0_wready, s1_wready} !== 6'b0) begin
      bad++; $display("FAIL reset_ready got=%b exp=000000",
                      {s0_awready, s1_awready, s0_arready, s1_arready, s0_wready, s1_wready}); end
    total++; if ({s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid, m_bready, m_rready} !== 6'b0) begin
      bad++; $display("FAIL reset_resp got=%b exp=000000",
                      {s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid, m_bready, m_rready}); end
    total++; if ({m_awlen, m_awsize, m_awburst, m_arlen, m_arsize, m_arburst} !== {8'd7, 3'd3, 2'd1, 8'd7, 3'd3, 2'd1}) begin
      bad++; $display("FAIL burst_const got=%h", {m_awlen, m_awsize, m_awburst, m_arlen, m_arsize, m_arburst}); end
  endtask

  task automatic test_single_write();
    reset_dut();
    s0_awaddr = 29'h100; s0_awid = 2'b10; s0_awvalid = 1; #1;
    total++; if (s0_awready !== 1'b1) begin bad++; $display("FAIL sw_awready got=%b exp=1", s0_awready); end
    @(negedge clk); s0_awvalid = 0; #1;
    total++; if ({m_awvalid, m_awaddr, m_awid} !== {1'b1, 29'h100, 2'b00}) begin
      bad++; $display("FAIL sw_maw got=%b/%h/%b exp=1/100/00", m_awvalid, m_awaddr, m_awid); end
    m_awready = 1;
    @(negedge clk); m_awready = 0; #1;
    total++; if (m_awvalid !== 1'b0) begin bad++; $display("FAIL sw_awvalid_drop got=%b exp=0", m_awvalid); end
    m_wready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s0_wdata = 64'hD0D0_0000_0000_0000 + 64'(i); s0_wlast = (i == 7); s0_wvalid = 1; #1;
      total++; if ({m_wvalid, m_wdata, m_wlast, s0_wready, s1_wready} !==
                   {1'b1, 64'hD0D0_0000_0000_0000 + 64'(i), (i == 7), 1'b1, 1'b0}) begin
        bad++; $display("FAIL sw_beat%0d got=%b/%h/%b exp=1/%h/%b", i, m_wvalid, m_wdata, m_wlast,
                        64'hD0D0_0000_0000_0000 + 64'(i), (i == 7)); end
    end
    @(negedge clk); s0_wlast = 0; #1;
    total++; if ({m_wvalid, s0_wready} !== 2'b00) begin
      bad++; $display("FAIL sw_fifo_empty got=%b exp=00", {m_wvalid, s0_wready}); end
    s0_wvalid = 0; m_wready = 0;
  endtask

  task automatic test_rr_order();
    int n, cyc, bc0, bc1, ep, eb;
    logic [3:0] got;
    logic dual;
    logic [63:0] ed;
    reset_dut();
    m_awready = 1; m_wready = 1;
    for (int r = 0; r < 2; r++) begin
      n = 0; cyc = 0; got = '0; dual = 0;
      s0_awvalid = 1; s1_awvalid = 1;
      while (n < 4 && cyc < 40) begin
        #1;
        if (s0_awready && s1_awready) dual = 1;
        if (s0_awready) begin got[3-n] = 1'b0; n++; end
        else if (s1_awready) begin got[3-n] = 1'b1; n++; end
        @(negedge clk); cyc++;
      end
      s0_awvalid = 0; s1_awvalid = 0;
      total++; if ({n == 4, dual, got} !== {1'b1, 1'b0, 4'b0101}) begin
        bad++; $display("FAIL rr_grants r%0d got=n%0d dual%b seq%b exp=n4 dual0 seq0101", r, n, dual, got); end
      repeat (2) @(negedge clk);
      bc0 = 0; bc1 = 0;
      s1_wdata = wd(1, r, 0); s1_wlast = 0; s1_wvalid = 1;
      for (int k = 0; k < 3; k++) begin
        #1;
        total++; if ({m_wvalid, s1_wready} !== 2'b00) begin
          bad++; $display("FAIL rr_s1_early r%0d got=%b exp=00", r, {m_wvalid, s1_wready}); end
        @(negedge clk);
      end
      for (int k = 0; k < 32; k++) begin
        s0_wdata = wd(0, r, bc0); s0_wlast = (bc0 % 8 == 7); s0_wvalid = 1;
        s1_wdata = wd(1, r, bc1); s1_wlast = (bc1 % 8 == 7); s1_wvalid = 1;
        #1;
        ep = (k / 8) % 2;
        eb = (ep == 0) ? bc0 : bc1;
        ed = wd(ep, r, eb);
        total++; if ({m_wvalid, m_wdata, m_wlast, s0_wready, s1_wready} !==
                     {1'b1, ed, (eb % 8 == 7), (ep == 0), (ep == 1)}) begin
          bad++; $display("FAIL rr_wbeat r%0d k%0d got=%h/%b/%b%b exp=%h/%b port%0d", r, k, m_wdata, m_wlast,
                          s0_wready, s1_wready, ed, (eb % 8 == 7), ep); end
        if (ep == 0) bc0++; else bc1++;
        @(negedge clk);
      end
      s0_wvalid = 0; s1_wvalid = 0; s0_wlast = 0; s1_wlast = 0; #1;
      total++; if (m_wvalid !== 1'b0) begin bad++; $display("FAIL rr_drain r%0d got=%b exp=0", r, m_wvalid); end
      @(negedge clk);
    end
  endtask

  task automatic test_aw_stall();
    reset_dut();
    s0_awaddr = 29'h1234; s0_awid = 2'b01; s0_awvalid = 1; #1;
    total++; if (s0_awready !== 1'b1) begin bad++; $display("FAIL st_grant got=%b exp=1", s0_awready); end
    @(negedge clk);
    s0_awaddr = 29'h5555; s1_awaddr = 29'h0ABC; s1_awid = 2'b00; s1_awvalid = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++; if ({m_awvalid, m_awaddr, m_awid, s0_awready, s1_awready} !== {1'b1, 29'h1234, 2'b01, 2'b00}) begin
        bad++; $display("FAIL st_hold c%0d got=%b/%h/%b/%b%b exp=1/1234/01/00", i, m_awvalid, m_awaddr,
                        m_awid, s0_awready, s1_awready); end
      @(negedge clk);
    end
    m_awready = 1;
    @(negedge clk); m_awready = 0; #1;
    total++; if ({s0_awready, s1_awready} !== 2'b01) begin
      bad++; $display("FAIL st_next_grant got=%b exp=01", {s0_awready, s1_awready}); end
    @(negedge clk); s0_awvalid = 0; s1_awvalid = 0; #1;
    total++; if ({m_awvalid, m_awaddr, m_awid} !== {1'b1, 29'h0ABC, 2'b10}) begin
      bad++; $display("FAIL st_second_aw got=%b/%h/%b exp=1/0abc/10", m_awvalid, m_awaddr, m_awid); end
  endtask

  task automatic test_fifo_full();
    int n, late;
    reset_dut();
    m_awready = 1; m_wready = 0;
    s0_awaddr = 29'h400; s0_awvalid = 1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      #1; if (s0_awready) n++;
      @(negedge clk);
    end
    total++; if (n !== 4) begin bad++; $display("FAIL ff_grants got=%0d exp=4", n); end
    s0_wdata = 64'h0; s0_wlast = 0; s0_wvalid = 1; #1;
    total++; if ({m_wvalid, s0_wready} !== 2'b10) begin
      bad++; $display("FAIL ff_wstall got=%b exp=10", {m_wvalid, s0_wready}); end
    m_wready = 1; late = 0;
    for (int i = 0; i < 8; i++) begin
      s0_wdata = 64'(i); s0_wlast = (i == 7); #1;
      if (s0_awready) late++;
      @(negedge clk);
    end
    s0_wvalid = 0; s0_wlast = 0; #1;
    total++; if ({late == 0, s0_awready} !== 2'b11) begin
      bad++; $display("FAIL ff_fifth_aw early=%0d ready_after_pop=%b exp=0/1", late, s0_awready); end
    @(negedge clk); s0_awvalid = 0;
  endtask

  task automatic test_ar();
    reset_dut();
    s0_araddr = 29'h200; s0_arid = 2'b11; s1_araddr = 29'h300; s1_arid = 2'b01;
    s0_arvalid = 1; s1_arvalid = 1; #1;
    total++; if ({s0_arready, s1_arready} !== 2'b10) begin
      bad++; $display("FAIL ar_first got=%b exp=10", {s0_arready, s1_arready}); end
    @(negedge clk); s0_arvalid = 0; #1;
    total++; if ({m_arvalid, m_araddr, m_arid, s0_arready, s1_arready} !== {1'b1, 29'h200, 2'b01, 2'b00}) begin
      bad++; $display("FAIL ar_issue0 got=%b/%h/%b exp=1/200/01", m_arvalid, m_araddr, m_arid); end
    m_arready = 1;
    @(negedge clk); m_arready = 0; #1;
    total++; if ({s0_arready, s1_arready} !== 2'b01) begin
      bad++; $display("FAIL ar_second got=%b exp=01", {s0_arready, s1_arready}); end
    @(negedge clk); s1_arvalid = 0; #1;
    total++; if ({m_arvalid, m_araddr, m_arid} !== {1'b1, 29'h300, 2'b11}) begin
      bad++; $display("FAIL ar_issue1 got=%b/%h/%b exp=1/300/11", m_arvalid, m_araddr, m_arid); end
  endtask

  task automatic test_read_route();
    int beat, c;
    logic er;
    reset_dut();
    m_rid = 2'b10; m_rresp = 2'b00; m_rvalid = 1; s0_rready = 1;
    beat = 0; c = 0;
    while (beat < 8 && c < 40) begin
      er = (c % 2 == 0);
      s1_rready = er; m_rdata = 64'h5200 + 64'(beat); m_rlast = (beat == 7); #1;
      total++; if ({s0_rvalid, s1_rvalid, m_rready, s1_rdata, s1_rid, s1_rlast} !==
                   {1'b0, 1'b1, er, 64'h5200 + 64'(beat), 2'b10, (beat == 7)}) begin
        bad++; $display("FAIL rd_beat%0d got=%b%b%b/%h/%b exp=01%b/%h/%b", beat, s0_rvalid, s1_rvalid, m_rready,
                        s1_rdata, s1_rlast, er, 64'h5200 + 64'(beat), (beat == 7)); end
      if (er) beat++;
      c++;
      @(negedge clk);
    end
    total++; if (beat !== 8) begin bad++; $display("FAIL rd_count got=%0d exp=8", beat); end
    m_rvalid = 0; m_rlast = 0;
  endtask

  task automatic test_bresp_route();
    reset_dut();
    m_bvalid = 1; m_bid = 2'b01; m_bresp = 2'b00; s0_bready = 0; s1_bready = 1; #1;
    total++; if ({s0_bvalid, s1_bvalid, m_bready, s0_bid} !== {1'b1, 1'b0, 1'b0, 2'b01}) begin
      bad++; $display("FAIL b_s0 got=%b%b%b/%b exp=100/01", s0_bvalid, s1_bvalid, m_bready, s0_bid); end
    s0_bready = 1; #1;
    total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL b_s0_ready got=%b exp=1", m_bready); end
    m_bid = 2'b11; s1_bready = 0; #1;
    total++; if ({s0_bvalid, s1_bvalid, m_bready, s1_bid} !== {1'b0, 1'b1, 1'b0, 2'b11}) begin
      bad++; $display("FAIL b_s1 got=%b%b%b/%b exp=010/11", s0_bvalid, s1_bvalid, m_bready, s1_bid); end
    @(negedge clk); m_bvalid = 0;
  endtask

`ifdef RBUS_AXI_ARB_ERR_EN
  task automatic test_err();
    reset_dut();
    m_bvalid = 1; m_bid = 2'b00; m_bresp = 2'b10; s0_bready = 1; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", err); end
    @(negedge clk); m_bvalid = 0; m_bresp = 2'b00; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    repeat (5) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    rst = 1'b0; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    rst = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_write();
    test_rr_order();
    test_aw_stall();
    test_fifo_full();
    test_ar();
    test_read_route();
    test_bresp_route();
`ifdef RBUS_AXI_ARB_ERR_EN
    test_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
